// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: address/instruction widths and the NOP encoding.
package cpu_pkg;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP = 32'hD503201F;
endpackage

// File: rtl/br_target.sv
// Branch target generator: sign-extends the selected immediate, scales it to
// bytes and adds it to the PC of the instruction sitting in decode.
module br_target
    import cpu_pkg::*;
(
    input  addr_t       pc_q,
    input  logic [25:0] imm,
    input  logic        uncond_br,
    output addr_t       target
);
    // Word offset; the two low zero bits are appended at the add.
    logic [ADDR_W-3:0] offset;

    always_comb begin
        if (uncond_br) begin
            offset = {{(ADDR_W-2-26){imm[25]}}, imm[25:0]};
        end else begin
            offset = {{(ADDR_W-2-19){imm[23]}}, imm[23:5]};
        end
    end

    assign target = pc_q + {offset, 2'b00};
endmodule

// File: rtl/if_staged.sv
// Instruction-fetch stage with IF/DEC pipeline register, one architectural
// delay slot, register and PC-relative branches, and a stall hold.
module if_staged
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic        pc_rd,
    input  addr_t       Reg2,
    input  instr_t      imem_data,
    output addr_t       imem_addr,
    output instr_t      instruction,
    output addr_t       PCPlusFour,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);
    addr_t pc;
    addr_t pc_q;
    addr_t pc_plus4;
    addr_t br_addr;
    addr_t pc_next;

    assign pc_plus4  = pc + 64'd4;
    assign imem_addr = pc;

    br_target u_br_target (
        .pc_q      (pc_q),
        .imm       (instruction[25:0]),
        .uncond_br (UncondBr),
        .target    (br_addr)
    );

    // Register branch outranks a PC-relative branch; the fetch in flight is
    // the delay slot and is never flushed.
    always_comb begin
        pc_next = pc_plus4;
        if (pc_rd) begin
            pc_next = {Reg2[ADDR_W-1:2], 2'b00};
        end else if (BrTaken) begin
            pc_next = br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc           <= RESET_PC;
            pc_q         <= RESET_PC;
            instruction  <= NOP;
            PCPlusFour   <= RESET_PC + 64'd4;
            fetch_count  <= 32'd0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_next;
            pc_q        <= pc;
            instruction <= imem_data;
            PCPlusFour  <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
            if (pc_rd && (Reg2[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end
endmodule
